// File: rtl/lock_seq_ctrl.sv
// Combination-lock sequencer: turns scanned key events into buffer commands and
// runs the INIT/SECURE/OPEN/LOCKOUT/ALARM lock FSM with status LEDs.
module lock_seq_ctrl #(
  parameter int unsigned MAX_TRIES  = 3,
  parameter int unsigned LOCK_TICKS = 500,
  parameter int unsigned BLINK_HALF = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_strobe,
  input  logic [4:0]  key_code,
  input  logic [31:0] buf_value,
  output logic        buf_push,
  output logic [3:0]  buf_char,
  output logic        buf_bksp,
  output logic        buf_clr,
  output logic [3:0]  digit_cnt,
  output logic [2:0]  state,
  output logic [3:0]  fail_cnt,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned LOCK_W  = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS) : 1;
  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [3:0]         MAX_FAILS  = 4'(MAX_TRIES);
  localparam logic [3:0]         MAX_DIGITS = 4'd8;
  localparam logic [LOCK_W-1:0]  LOCK_LOAD  = LOCK_W'(LOCK_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [4:0]         KEY_W      = 5'd16;
  localparam logic [4:0]         KEY_X      = 5'd17;
  localparam logic [4:0]         KEY_Y      = 5'd18;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_SECURE  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_ALARM   = 3'd4
  } state_t;

  state_t              st;
  logic [31:0]         passphrase;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [BLINK_W-1:0]  blink_cnt;
  logic [3:0]          fail_inc;
  logic                is_digit;
  logic                entry_mode;
  logic                pass_match;

  assign state      = st;
  assign fail_inc   = fail_cnt + 4'd1;
  assign is_digit   = ~key_code[4];
  assign entry_mode = (st == ST_INIT) || (st == ST_SECURE) || (st == ST_OPEN);
  assign pass_match = (buf_value == passphrase);

  // Lock FSM, command pulses and LEDs; LEDs are updated alongside every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_INIT;
      passphrase <= 32'd0;
      lock_cnt   <= '0;
      blink_cnt  <= '0;
      digit_cnt  <= 4'd0;
      fail_cnt   <= 4'd0;
      buf_push   <= 1'b0;
      buf_char   <= 4'd0;
      buf_bksp   <= 1'b0;
      buf_clr    <= 1'b0;
      red        <= 1'b0;
      green      <= 1'b0;
      blue       <= 1'b0;
    end else begin
      buf_push <= 1'b0;
      buf_bksp <= 1'b0;
      buf_clr  <= 1'b0;
      if (entry_mode) begin
        if (key_strobe) begin
          if (is_digit) begin
            if (digit_cnt != MAX_DIGITS) begin
              buf_push  <= 1'b1;
              buf_char  <= key_code[3:0];
              digit_cnt <= digit_cnt + 4'd1;
            end
          end else if (key_code == KEY_X) begin
            if (digit_cnt != 4'd0) begin
              buf_bksp  <= 1'b1;
              digit_cnt <= digit_cnt - 4'd1;
            end
          end else if (key_code == KEY_Y) begin
            if (st == ST_OPEN) begin
              buf_clr   <= 1'b1;
              digit_cnt <= 4'd0;
              st        <= ST_SECURE;
              green     <= 1'b0;
              blue      <= 1'b1;
            end
          end else if ((key_code == KEY_W) && (digit_cnt != 4'd0)) begin
            buf_clr   <= 1'b1;
            digit_cnt <= 4'd0;
            if (st == ST_INIT) begin
              passphrase <= buf_value;
              st         <= ST_SECURE;
              blue       <= 1'b1;
            end else if (st == ST_OPEN) begin
              passphrase <= buf_value;
            end else if (pass_match) begin
              st       <= ST_OPEN;
              fail_cnt <= 4'd0;
              blue     <= 1'b0;
              green    <= 1'b1;
            end else begin
              blue     <= 1'b0;
              red      <= 1'b1;
              fail_cnt <= (fail_inc >= MAX_FAILS) ? MAX_FAILS : fail_inc;
              if (fail_inc >= MAX_FAILS) begin
                st        <= ST_ALARM;
                blink_cnt <= '0;
              end else begin
                st       <= ST_LOCKOUT;
                lock_cnt <= LOCK_LOAD;
              end
            end
          end
        end
      end else if (st == ST_LOCKOUT) begin
        if (lock_cnt == '0) begin
          st   <= ST_SECURE;
          red  <= 1'b0;
          blue <= 1'b1;
        end else begin
          lock_cnt <= lock_cnt - LOCK_W'(1);
        end
      end else if (st == ST_ALARM) begin
        // Red starts high on entry and flips after each full half-period.
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          red       <= ~red;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end else begin
        st    <= ST_INIT;
        red   <= 1'b0;
        green <= 1'b0;
        blue  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Bench for lock_seq_ctrl: directed test-plan sequence plus random key traffic,
// every cycle compared against an event-level model of the lock.
module tb_lock_seq_ctrl;
  localparam int MAX_TRIES  = 3;
  localparam int LOCK_TICKS = 500;
  localparam int BLINK_HALF = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_strobe = 1'b0;
  logic [4:0]  key_code = 5'd0;
  logic [31:0] buf_value = 32'd0;
  logic        buf_push, buf_bksp, buf_clr, red, green, blue;
  logic [3:0]  buf_char, digit_cnt, fail_cnt;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  // Model state: mode 0..4, counts, ages since LOCKOUT/ALARM entry, buffer contents.
  int          m_state, m_cnt, m_fail, lock_age, alarm_age;
  logic [31:0] m_pass, m_buf;
  logic        e_push, e_bksp, e_clr;
  logic [3:0]  e_char;
  int          push_seen, bksp_seen, clr_seen;

  lock_seq_ctrl #(.MAX_TRIES(MAX_TRIES), .LOCK_TICKS(LOCK_TICKS), .BLINK_HALF(BLINK_HALF)) dut (
    .clk(clk), .rst_n(rst_n), .key_strobe(key_strobe), .key_code(key_code),
    .buf_value(buf_value), .buf_push(buf_push), .buf_char(buf_char),
    .buf_bksp(buf_bksp), .buf_clr(buf_clr), .digit_cnt(digit_cnt), .state(state),
    .fail_cnt(fail_cnt), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_fail = 0; lock_age = 0; alarm_age = 0;
    m_pass = 32'd0; m_buf = 32'd0;
    e_push = 1'b0; e_bksp = 1'b0; e_clr = 1'b0; e_char = 4'd0;
  endfunction

  // The buffer acts on a pulse at the edge that ends the pulse cycle.
  function automatic void apply_buf();
    if (e_push) m_buf = {m_buf[27:0], e_char};
    if (e_bksp) m_buf = m_buf >> 4;
    if (e_clr)  m_buf = 32'd0;
  endfunction

  function automatic void model_step(input logic s, input logic [4:0] c, input logic [31:0] bv);
    e_push = 1'b0; e_bksp = 1'b0; e_clr = 1'b0;
    if (m_state <= 2) begin
      if (s) begin
        if (c < 5'd16) begin
          if (m_cnt < 8) begin e_push = 1'b1; e_char = c[3:0]; m_cnt++; end
        end else if (c == 5'd17) begin
          if (m_cnt > 0) begin e_bksp = 1'b1; m_cnt--; end
        end else if (c == 5'd18) begin
          if (m_state == 2) begin e_clr = 1'b1; m_cnt = 0; m_state = 1; end
        end else if (c == 5'd16 && m_cnt > 0) begin
          e_clr = 1'b1; m_cnt = 0;
          if (m_state == 0) begin m_pass = bv; m_state = 1; end
          else if (m_state == 2) m_pass = bv;
          else if (bv == m_pass) begin m_state = 2; m_fail = 0; end
          else begin
            m_fail = (m_fail + 1 > MAX_TRIES) ? MAX_TRIES : m_fail + 1;
            if (m_fail == MAX_TRIES) begin m_state = 4; alarm_age = 0; end
            else begin m_state = 3; lock_age = 0; end
          end
        end
      end
    end else if (m_state == 3) begin
      lock_age++;
      if (lock_age == LOCK_TICKS) m_state = 1;
    end else begin
      alarm_age++;
    end
  endfunction

  task automatic compare_all();
    logic exp_red;
    exp_red = (m_state == 3) || (m_state == 4 && ((alarm_age / BLINK_HALF) % 2 == 0));
    chk("state", 32'(state), 32'(m_state));
    chk("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
    chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    chk("buf_push", 32'(buf_push), 32'(e_push));
    chk("buf_bksp", 32'(buf_bksp), 32'(e_bksp));
    chk("buf_clr", 32'(buf_clr), 32'(e_clr));
    chk("buf_char", 32'(buf_char), 32'(e_char));
    chk("red", 32'(red), 32'(exp_red));
    chk("green", 32'(green), 32'(m_state == 2));
    chk("blue", 32'(blue), 32'(m_state == 1));
  endtask

  // Called just after a falling edge; drives one cycle of inputs and checks the result.
  task automatic step(input logic s, input logic [4:0] c);
    apply_buf();
    key_strobe = s; key_code = c; buf_value = m_buf;
    model_step(s, c, m_buf);
    @(posedge clk); #1;
    compare_all();
    if (buf_push) push_seen++;
    if (buf_bksp) bksp_seen++;
    if (buf_clr)  clr_seen++;
    @(negedge clk);
  endtask

  task automatic key(input logic [4:0] c);
    step(1'b1, c); step(1'b0, 5'd0); step(1'b0, 5'd0);
  endtask

  // Reset lands mid low-phase, so the check below sees no clock edge.
  task automatic do_reset();
    key_strobe = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_fail", 32'(fail_cnt), 32'd0);
    chk("async_rst_digits", 32'(digit_cnt), 32'd0);
    chk("async_rst_leds", 32'({red, green, blue}), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [4:0] rand_code();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 50) return 5'($urandom_range(0, 1));
    if (r < 70) return 5'd16;
    if (r < 82) return 5'd17;
    if (r < 90) return 5'd18;
    return 5'($urandom_range(19, 31));
  endfunction

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Enrol 0x1234.
    push_seen = 0;
    key(5'd1); key(5'd2); key(5'd3); key(5'd4);
    chk("enrol_pushes", 32'(push_seen), 32'd4);
    chk("enrol_digits", 32'(digit_cnt), 32'd4);
    chk("enrol_char", 32'(buf_char), 32'd4);
    key(5'd16);
    chk("enrol_state", 32'(state), 32'd1);
    chk("enrol_blue", 32'(blue), 32'd1);

    // Correct entry with a backspace, then relock.
    bksp_seen = 0;
    key(5'd1); key(5'd2); key(5'd17); key(5'd2); key(5'd3); key(5'd4); key(5'd16);
    chk("open_bksp", 32'(bksp_seen), 32'd1);
    chk("open_state", 32'(state), 32'd2);
    chk("open_green", 32'(green), 32'd1);
    chk("open_fail", 32'(fail_cnt), 32'd0);
    key(5'd18);
    chk("relock_state", 32'(state), 32'd1);

    // Empty W ignored; ninth digit ignored.
    clr_seen = 0;
    key(5'd16);
    chk("empty_w_clr", 32'(clr_seen), 32'd0);
    chk("empty_w_state", 32'(state), 32'd1);
    push_seen = 0;
    for (int i = 0; i < 9; i++) key(5'd5);
    chk("nine_pushes", 32'(push_seen), 32'd8);
    chk("nine_digits", 32'(digit_cnt), 32'd8);
    for (int i = 0; i < 8; i++) key(5'd17);

    // Two non-final failures, each with a full lockout under key traffic.
    for (int f = 1; f <= 2; f++) begin
      push_seen = 0;
      key(5'd9); key(5'd16);
      chk("lock_state", 32'(state), 32'd3);
      chk("lock_red", 32'(red), 32'd1);
      chk("lock_fail", 32'(fail_cnt), 32'(f));
      push_seen = 0; clr_seen = 0;
      for (int a = 3; a < LOCK_TICKS; a++) step(1'($urandom_range(0, 1)), rand_code());
      chk("lock_quiet", 32'(push_seen + clr_seen), 32'd0);
      chk("lock_last_cycle", 32'(state), 32'd3);
      step(1'b0, 5'd0);
      chk("lock_exit", 32'(state), 32'd1);
    end

    // Third failure: alarm and blink.
    key(5'd9); key(5'd16);
    chk("alarm_state", 32'(state), 32'd4);
    for (int a = 3; a <= 40; a++) begin
      step(1'b1, (a % 2 == 0) ? 5'd16 : 5'd18);
      if (a == 11) chk("blink_11", 32'(red), 32'd1);
      if (a == 12) chk("blink_12", 32'(red), 32'd0);
      if (a == 23) chk("blink_23", 32'(red), 32'd0);
      if (a == 24) chk("blink_24", 32'(red), 32'd1);
    end
    chk("alarm_sticky", 32'(state), 32'd4);
    do_reset();

    // Reset mid-lockout at cycle 200, then rekey in OPEN.
    key(5'd1); key(5'd16);
    key(5'd2); key(5'd16);
    chk("mid_lock_state", 32'(state), 32'd3);
    for (int a = 3; a < 200; a++) step(1'b0, 5'd0);
    do_reset();
    key(5'd5); key(5'd16);
    key(5'd5); key(5'd16);
    chk("reopen_state", 32'(state), 32'd2);
    key(5'd7); key(5'd7); key(5'd16);
    chk("rekey_state", 32'(state), 32'd2);
    key(5'd18);
    key(5'd7); key(5'd7); key(5'd16);
    chk("rekey_open", 32'(state), 32'd2);

    // Random key traffic with occasional asynchronous resets.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 999) == 0) do_reset();
        else step(1'($urandom_range(0, 99) < 40), rand_code());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
